fetch_queue_unit: RTL

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

---
 rtl/fetch_queue_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch front end with a small in-order queue.
// Requests go out under a credit rule, so accepted requests plus queued entries
// never exceed DEPTH. A redirect flushes the queue and drops the responses that
// are still in flight. The request address of each in-flight fetch is kept in
// its own FIFO so that every queued entry can carry pc+4.
// Optional build macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a response
// that arrives while the queue is empty goes straight to the dequeue port in
// the same cycle.
module fetch_queue_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req_valid,
  output logic [31:0]                  imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_rsp_valid,
  input  logic [31:0]                  imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         deq_valid,
  output logic [31:0]                  deq_instr,
  output logic [31:0]                  deq_pc_plus4,
  input  logic                         deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam int unsigned PW        = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] ZERO_C    = CW'(0);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [PW-1:0] ZERO_P    = PW'(0);
  localparam logic [PW-1:0] ONE_P     = PW'(1);
  localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic [CW-1:0] outstanding_r, outstanding_s;
  logic [CW-1:0] discard_r, discard_s;
  logic [CW-1:0] occ_r, occ_s;
  logic          req_valid_r, req_valid_s;
  logic [PW-1:0] head_r, tail_r, a_head_r, a_tail_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc4_mem_r   [DEPTH];
  logic [31:0]   addr_mem_r  [DEPTH];

  logic          accept_s, rsp_hit_s, bypass_s, bypass_take_s, enq_s, deq_s;
  logic [31:0]   rsp_pc4_s;

  // Handshake qualifiers for this cycle; responses with nothing outstanding are ignored.
  always_comb begin
    accept_s  = req_valid_r & imem_req_ready;
    rsp_hit_s = imem_rsp_valid & (outstanding_r != ZERO_C);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s  = rsp_hit_s & (state_r == ST_FETCH) & (occ_r == ZERO_C) & ~redirect_valid;
`else
    bypass_s  = 1'b0;
`endif
    bypass_take_s = bypass_s & deq_ready;
    enq_s     = rsp_hit_s & (state_r == ST_FETCH) & ~redirect_valid & ~bypass_take_s;
    deq_s     = (occ_r != ZERO_C) & deq_ready;
    rsp_pc4_s = addr_mem_r[a_head_r] + 32'd4;
  end

  // Next-state computation for the FSM, fetch pointer and counters.
  always_comb begin
    state_s       = state_r;
    fetch_pc_s    = fetch_pc_r;
    outstanding_s = outstanding_r;
    discard_s     = discard_r;
    occ_s         = occ_r;
    if (accept_s && !rsp_hit_s) begin
      outstanding_s = outstanding_r + ONE_C;
    end else if (!accept_s && rsp_hit_s) begin
      outstanding_s = outstanding_r - ONE_C;
    end else begin
      outstanding_s = outstanding_r;
    end
    if (redirect_valid) begin
      // A request accepted in this same cycle is already in outstanding_s, so it is discarded too.
      fetch_pc_s = redirect_pc;
      occ_s      = ZERO_C;
      discard_s  = outstanding_s;
      if (outstanding_s != ZERO_C) begin
        state_s = ST_FLUSH;
      end else begin
        state_s = ST_FETCH;
      end
    end else begin
      if (accept_s) begin
        fetch_pc_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_s = fetch_pc_r;
      end
      if (enq_s && !deq_s) begin
        occ_s = occ_r + ONE_C;
      end else if (!enq_s && deq_s) begin
        occ_s = occ_r - ONE_C;
      end else begin
        occ_s = occ_r;
      end
      case (state_r)
        ST_FETCH: begin
          state_s   = ST_FETCH;
          discard_s = discard_r;
        end
        ST_FLUSH: begin
          if (rsp_hit_s) begin
            if (discard_r > ONE_C) begin
              discard_s = discard_r - ONE_C;
              state_s   = ST_FLUSH;
            end else begin
              discard_s = ZERO_C;
              state_s   = ST_FETCH;
            end
          end else if (discard_r == ZERO_C) begin
            discard_s = ZERO_C;
            state_s   = ST_FETCH;
          end else begin
            discard_s = discard_r;
            state_s   = ST_FLUSH;
          end
        end
        default: begin
          discard_s = ZERO_C;
          state_s   = ST_FETCH;
        end
      endcase
    end
    req_valid_s = (state_s == ST_FETCH) && (({1'b0, occ_s} + {1'b0, outstanding_s}) < DEPTH_W);
  end

  // Control registers: FSM state, fetch pointer, credit counters, request valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_FETCH;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= ZERO_C;
      discard_r     <= ZERO_C;
      occ_r         <= ZERO_C;
      req_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      fetch_pc_r    <= fetch_pc_s;
      outstanding_r <= outstanding_s;
      discard_r     <= discard_s;
      occ_r         <= occ_s;
      req_valid_r   <= req_valid_s;
    end
  end

  // Queue and request-address FIFO pointers; a redirect empties the queue only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r   <= ZERO_P;
      tail_r   <= ZERO_P;
      a_head_r <= ZERO_P;
      a_tail_r <= ZERO_P;
    end else begin
      if (redirect_valid) begin
        head_r <= ZERO_P;
        tail_r <= ZERO_P;
      end else begin
        head_r <= deq_s ? (head_r + ONE_P) : head_r;
        tail_r <= enq_s ? (tail_r + ONE_P) : tail_r;
      end
      a_tail_r <= accept_s  ? (a_tail_r + ONE_P) : a_tail_r;
      a_head_r <= rsp_hit_s ? (a_head_r + ONE_P) : a_head_r;
    end
  end

  // Entry storage: instruction with pc+4, and the address of each accepted request.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      instr_mem_r[tail_r] <= imem_rsp_data;
      pc4_mem_r[tail_r]   <= rsp_pc4_s;
    end
    if (accept_s) begin
      addr_mem_r[a_tail_r] <= fetch_pc_r;
    end
  end

  // Dequeue port: head entry, else bypassed response, else an idle NOP.
  always_comb begin
    if (occ_r != ZERO_C) begin
      deq_valid    = 1'b1;
      deq_instr    = instr_mem_r[head_r];
      deq_pc_plus4 = pc4_mem_r[head_r];
    end else if (bypass_s) begin
      deq_valid    = 1'b1;
      deq_instr    = imem_rsp_data;
      deq_pc_plus4 = rsp_pc4_s;
    end else begin
      deq_valid    = 1'b0;
      deq_instr    = NOP_INSTR;
      deq_pc_plus4 = 32'h0000_0000;
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = fetch_pc_r;
  assign occupancy      = occ_r;

endmodule
